// File: rtl/regfile_scoreboard_if.sv
// Decode-issue, writeback-request and register-file-write bundle for regfile_scoreboard.
// master: pipeline side (decode + writeback sources); slave: the scoreboard.
interface regfile_scoreboard_if #(
  parameter int N = 32
);
  // Decode-stage instruction
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic [4:0]   issue_rs1;
  logic [4:0]   issue_rs2;
  logic         issue_use_rs1;
  logic         issue_use_rs2;
  logic         issue_we;
  logic         stall;

  // ALU writeback request
  logic         alu_valid;
  logic [4:0]   alu_rd;
  logic [N-1:0] alu_data;
  logic         alu_ready;

  // Load writeback request
  logic         mem_valid;
  logic [4:0]   mem_rd;
  logic [N-1:0] mem_data;
  logic         mem_ready;

  // Register-file write port and pending-write status
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [N-1:0] rf_wdata;
  logic [31:0]  busy_vec;

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
           issue_use_rs1, issue_use_rs2, issue_we,
           alu_valid, alu_rd, alu_data,
           mem_valid, mem_rd, mem_data,
    input  stall, alu_ready, mem_ready,
           rf_we, rf_waddr, rf_wdata, busy_vec
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
           issue_use_rs1, issue_use_rs2, issue_we,
           alu_valid, alu_rd, alu_data,
           mem_valid, mem_rd, mem_data,
    output stall, alu_ready, mem_ready,
           rf_we, rf_waddr, rf_wdata, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register scoreboard: tracks pending writes, stalls hazarded issues and
// arbitrates two writeback sources (ALU, load) onto one register-file write port.
// Optional feature: define SCOREBOARD_BYPASS_EN to let a register being written
// back in the current cycle stop counting as hazarded in that same cycle.
module regfile_scoreboard #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  localparam int unsigned NREG = 32;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_eff;
  logic            prio_q;     // 0: load preferred, 1: ALU preferred

  logic            grant_alu;
  logic            grant_mem;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [N-1:0]    wb_data;

  logic            haz_rs1;
  logic            haz_rs2;
  logic            haz_rd;
  logic            stall_c;
  logic            accept;

  // Two-source arbitration; nothing is granted while in reset
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst) begin
      if (bus.alu_valid && bus.mem_valid) begin
        grant_alu = prio_q;
        grant_mem = !prio_q;
      end else begin
        grant_alu = bus.alu_valid;
        grant_mem = bus.mem_valid;
      end
    end
  end

  // Select the granted writeback payload; zeros when idle
  always_comb begin
    wb_valid = grant_alu || grant_mem;
    wb_rd    = 5'd0;
    wb_data  = '0;
    if (grant_alu) begin
      wb_rd   = bus.alu_rd;
      wb_data = bus.alu_data;
    end else if (grant_mem) begin
      wb_rd   = bus.mem_rd;
      wb_data = bus.mem_data;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign bus.rf_we     = wb_valid && (wb_rd != 5'd0);
  assign bus.rf_waddr  = wb_rd;
  assign bus.rf_wdata  = wb_data;

`ifdef SCOREBOARD_BYPASS_EN
  // Busy view for hazard checks: the register written back this cycle is already free
  always_comb begin
    busy_eff = busy_q;
    if (wb_valid) busy_eff[wb_rd] = 1'b0;
  end
`else
  assign busy_eff = busy_q;
`endif

  // RAW hazards on sources and WAW hazard on the destination
  always_comb begin
    haz_rs1 = bus.issue_use_rs1 && (bus.issue_rs1 != 5'd0) && busy_eff[bus.issue_rs1];
    haz_rs2 = bus.issue_use_rs2 && (bus.issue_rs2 != 5'd0) && busy_eff[bus.issue_rs2];
    haz_rd  = bus.issue_we      && (bus.issue_rd  != 5'd0) && busy_eff[bus.issue_rd];
    stall_c = bus.issue_valid && (haz_rs1 || haz_rs2 || haz_rd || rst);
    accept  = bus.issue_valid && !stall_c;
  end

  assign bus.stall = stall_c;

  // Next busy bits: writeback clears first so a same-cycle issue set wins
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (accept && bus.issue_we && (bus.issue_rd != 5'd0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard state and arbitration priority
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      prio_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (bus.alu_valid && bus.mem_valid) prio_q <= !prio_q;
    end
  end

  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a driver applies directed and random
// stimulus, a behavioural model queues the expected response, a monitor compares.
module tb_regfile_scoreboard;

  localparam int N = 32;

  typedef struct {
    bit          stall;
    bit          alu_ready;
    bit          mem_ready;
    bit          rf_we;
    logic [4:0]  waddr;
    logic [N-1:0] wdata;
    logic [31:0] busy;
    bit          chk_busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  regfile_scoreboard_if #(.N(N)) bus ();

  regfile_scoreboard #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   driver_done = 1'b0;

  // Reference model state
  bit   m_busy[32];
  bit   m_prio;
  bit   last_stall;
  bit   last_ga;
  bit   last_gm;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_haz(input bit use_it, input int idx, input int wr);
    if (!use_it || idx == 0) return 1'b0;
    if (!m_busy[idx]) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    if (idx == wr) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Apply one cycle of inputs, queue the expected response, advance the model
  task automatic drive(input bit r, input bit iv, input int rd, input int rs1, input int rs2,
                       input bit u1, input bit u2, input bit we,
                       input bit av, input int ard, input logic [N-1:0] adat,
                       input bit mv, input int mrd, input logic [N-1:0] mdat,
                       input bit chkb);
    exp_t e;
    bit ga, gm;
    int wr;
    rst               = r;
    bus.issue_valid   = iv;
    bus.issue_rd      = 5'(rd);
    bus.issue_rs1     = 5'(rs1);
    bus.issue_rs2     = 5'(rs2);
    bus.issue_use_rs1 = u1;
    bus.issue_use_rs2 = u2;
    bus.issue_we      = we;
    bus.alu_valid     = av;
    bus.alu_rd        = 5'(ard);
    bus.alu_data      = adat;
    bus.mem_valid     = mv;
    bus.mem_rd        = 5'(mrd);
    bus.mem_data      = mdat;

    ga = 1'b0;
    gm = 1'b0;
    if (!r) begin
      if (av && mv) begin
        if (m_prio) ga = 1'b1; else gm = 1'b1;
      end else begin
        ga = av;
        gm = mv;
      end
    end
    wr = ga ? ard : (gm ? mrd : -1);

    e.alu_ready = ga;
    e.mem_ready = gm;
    e.rf_we     = (ga || gm) && (wr != 0);
    e.waddr     = (ga || gm) ? 5'(wr) : 5'd0;
    e.wdata     = ga ? adat : (gm ? mdat : '0);
    e.stall     = iv && (r || is_haz(u1, rs1, wr) || is_haz(u2, rs2, wr) || is_haz(we, rd, wr));
    for (int i = 0; i < 32; i++) e.busy[i] = m_busy[i];
    e.chk_busy  = chkb;
    exp_q.push_back(e);

    last_stall = e.stall;
    last_ga    = ga;
    last_gm    = gm;

    if (r) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_prio = 1'b0;
    end else begin
      if ((ga || gm) && wr != 0) m_busy[wr] = 1'b0;
      if (av && mv) m_prio = !m_prio;
      if (iv && !e.stall && we && rd != 0) m_busy[rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit r, input bit chkb);
    drive(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0, chkb);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall",     64'(bus.stall),     64'(e.stall));
        check("alu_ready", 64'(bus.alu_ready), 64'(e.alu_ready));
        check("mem_ready", 64'(bus.mem_ready), 64'(e.mem_ready));
        check("rf_we",     64'(bus.rf_we),     64'(e.rf_we));
        check("rf_waddr",  64'(bus.rf_waddr),  64'(e.waddr));
        check("rf_wdata",  64'(bus.rf_wdata),  64'(e.wdata));
        if (e.chk_busy) check("busy_vec", 64'(bus.busy_vec), 64'(e.busy));
      end
    end
  end

  // Driver: directed scenarios then constrained-random traffic
  initial begin
    bit a_pend, m_pend, i_pend;
    int a_rd, m_rd;
    logic [N-1:0] a_dat, m_dat;
    int i_rd, i_rs1, i_rs2;
    bit i_u1, i_u2, i_we;
    bit r;

    rst = 1'b1;
    bus.issue_valid = 0; bus.issue_rd = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0;
    bus.issue_use_rs1 = 0; bus.issue_use_rs2 = 0; bus.issue_we = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = '0;
    m_prio = 1'b0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    @(negedge clk);

    // Reset, then check the post-reset state
    idle(1, 0);
    idle(0, 1);

    // Issue rd=5, then a reader of x5 stalls until the ALU writes it back
    drive(0, 1, 5, 0, 0, 0, 0, 1, 0, 0, '0, 0, 0, '0, 1);
    drive(0, 1, 0, 5, 0, 1, 0, 0, 0, 0, '0, 0, 0, '0, 1);
    drive(0, 1, 0, 5, 0, 1, 0, 0, 1, 5, N'('hA5), 0, 0, '0, 1);
    drive(0, 1, 0, 5, 0, 1, 0, 0, 0, 0, '0, 0, 0, '0, 1);
    idle(0, 1);

    // Contention after reset alternates MEM, ALU, MEM, ALU
    idle(1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, N'('h11), 1, 2, N'('h22), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, N'('h11), 1, 3, N'('h33), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, N'('h44), 1, 3, N'('h33), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, N'('h44), 1, 6, N'('h66), 1);

    // Writeback to x0 is acknowledged without a write or busy change
    drive(0, 1, 7, 0, 0, 0, 0, 1, 0, 0, '0, 0, 0, '0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, N'('hFFFF_FFFF), 0, 0, '0, 1);
    idle(0, 1);

    // Same-cycle writeback clear and issue set of x9: the set wins
    drive(0, 1, 9, 0, 0, 0, 0, 1, 0, 0, '0, 0, 0, '0, 1);
    drive(0, 1, 9, 0, 0, 0, 0, 1, 0, 0, '0, 1, 9, N'('h99), 1);
    idle(0, 1);

    // busy_vec = 0xF00, reset while a load is waiting, then contention grants MEM
    idle(1, 0);
    for (int i = 8; i < 12; i++) drive(0, 1, i, 0, 0, 0, 0, 1, 0, 0, '0, 0, 0, '0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 1, 8, N'('h88), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, N'('hAA), 1, 8, N'('h88), 1);
    idle(0, 1);

    // Random traffic on a small register window; sources hold until acknowledged
    a_pend = 0; m_pend = 0; i_pend = 0;
    a_rd = 0; m_rd = 0; a_dat = '0; m_dat = '0;
    i_rd = 0; i_rs1 = 0; i_rs2 = 0; i_u1 = 0; i_u2 = 0; i_we = 0;
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(0, 59) == 0);
      if (!a_pend && $urandom_range(0, 9) < 4) begin
        a_pend = 1; a_rd = $urandom_range(0, 7); a_dat = N'($urandom);
      end
      if (!m_pend && $urandom_range(0, 9) < 4) begin
        m_pend = 1; m_rd = $urandom_range(0, 7); m_dat = N'($urandom);
      end
      if (!i_pend && $urandom_range(0, 9) < 6) begin
        i_pend = 1;
        i_rd = $urandom_range(0, 7); i_rs1 = $urandom_range(0, 7); i_rs2 = $urandom_range(0, 7);
        i_u1 = 1'($urandom); i_u2 = 1'($urandom); i_we = ($urandom_range(0, 3) != 0);
      end
      drive(r, i_pend, i_rd, i_rs1, i_rs2, i_u1, i_u2, i_we,
            a_pend, a_rd, a_dat, m_pend, m_rd, m_dat, 1);
      if (last_ga) a_pend = 0;
      if (last_gm) m_pend = 0;
      if (i_pend && !last_stall) i_pend = 0;
      else if (i_pend && $urandom_range(0, 7) == 0) i_pend = 0;
    end

    idle(0, 1);
    driver_done = 1'b1;
  end

  // Finish once all expectations are consumed, or give up after a bound
  initial begin
    int waited;
    waited = 0;
    while (!driver_done && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    @(negedge clk);
    check("driver_done", 64'(driver_done), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
